// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vend_pkg
// Brief    : Coin codes and classifier state encoding shared by the coin path.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam logic [1:0] COIN_NONE  = 2'b00;
    localparam logic [1:0] COIN_SMALL = 2'b10;
    localparam logic [1:0] COIN_LARGE = 2'b11;

    typedef enum logic [1:0] {
        CLS_IDLE = 2'd0,
        CLS_HIGH = 2'd1,
        CLS_JAM  = 2'd2
    } cls_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_pulse_classifier.sv
`default_nettype none
// ============================================================================
// Module   : coin_pulse_classifier
// Brief    : Two-flop synchroniser plus width classifier for one coin sensor.
// Revision : 1.0 - initial release
// ============================================================================
module coin_pulse_classifier
    import vend_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_PULSE  = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic sns,
    output logic valid,
    output logic jam_evt
);

    localparam int CW = $clog2(MAX_PULSE + 1);
    localparam logic [CW-1:0] c_deb = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] c_max = CW'(MAX_PULSE);

    logic          r_sync1;
    logic          r_sync2;
    cls_state_t    r_state;
    cls_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= CLS_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= sns;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt equals the number of synchronised-high cycles seen so far.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        valid       = 1'b0;
        jam_evt     = 1'b0;
        case (r_state)
            CLS_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = CLS_HIGH;
                    w_cnt_nxt   = CW'(1);
                end
            end
            CLS_HIGH: begin
                if (r_cnt == c_max) begin
                    w_state_nxt = CLS_JAM;
                    jam_evt     = 1'b1;
                end else if (!r_sync2) begin
                    valid       = (r_cnt >= c_deb);
                    w_state_nxt = CLS_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CLS_JAM: begin
                if (!r_sync2) begin
                    w_state_nxt = CLS_IDLE;
                end
            end
            default: w_state_nxt = CLS_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Brief    : Validates two coin sensors, buffers accepted coins and emits them
//            to the vending FSM as spaced single-cycle codes.
// Revision : 1.0 - initial release
// ============================================================================
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_PULSE  = 255,
    parameter int GAP_CYCLES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sns_small,
    input  logic       sns_large,
    input  logic       jam_clr,
    output logic [1:0] coin_out,
    output logic       reject,
    output logic       jam,
    output logic       fifo_full
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(FIFO_DEPTH - 1);
    localparam logic [GW-1:0] c_gap   = GW'(GAP_CYCLES);

    logic          w_valid_s;
    logic          w_valid_l;
    logic          w_jev_s;
    logic          w_jev_l;
    logic          w_pop;
    logic          w_push;
    logic          w_any;
    logic          w_rej_coin;
    logic [1:0]    w_code;
    logic [CW-1:0] w_count_nxt;

    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_coin;
    logic          r_reject;
    logic          r_jam;
    logic          r_full;

    coin_pulse_classifier #(
        .DEB_CYCLES (DEB_CYCLES),
        .MAX_PULSE  (MAX_PULSE)
    ) u_cls_small (
        .clk     (clk),
        .rst     (rst),
        .sns     (sns_small),
        .valid   (w_valid_s),
        .jam_evt (w_jev_s)
    );

    coin_pulse_classifier #(
        .DEB_CYCLES (DEB_CYCLES),
        .MAX_PULSE  (MAX_PULSE)
    ) u_cls_large (
        .clk     (clk),
        .rst     (rst),
        .sns     (sns_large),
        .valid   (w_valid_l),
        .jam_evt (w_jev_l)
    );

    // A pop frees the slot, so a push into a full buffer is allowed alongside it.
    always_comb begin
        w_pop       = (r_count != '0) && (r_gap == '0);
        w_any       = w_valid_s | w_valid_l;
        w_rej_coin  = w_any && ((w_valid_s && w_valid_l) || r_jam || (r_full && !w_pop));
        w_push      = w_any && !w_rej_coin;
        w_code      = w_valid_l ? COIN_LARGE : COIN_SMALL;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_gap    <= '0;
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            r_jam    <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == c_last) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_coin <= r_mem[r_rd];
                r_rd   <= (r_rd == c_last) ? '0 : r_rd + 1'b1;
                r_gap  <= c_gap;
            end else begin
                r_coin <= COIN_NONE;
                if (r_gap != '0) begin
                    r_gap <= r_gap - 1'b1;
                end
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_depth);
            r_reject <= w_rej_coin | w_jev_s | w_jev_l;
            // A fresh jam event outranks a simultaneous clear.
            if (w_jev_s || w_jev_l) begin
                r_jam <= 1'b1;
            end else if (jam_clr) begin
                r_jam <= 1'b0;
            end
        end
    end

    assign coin_out  = r_coin;
    assign reject    = r_reject;
    assign jam       = r_jam;
    assign fifo_full = r_full;

endmodule
`default_nettype wire
